// File: rtl/rec_array_serializer.sv
// Unpacks a flat ROWS x COLS array of {adr,val} records and streams one record per beat.
// Latency: first record 1 cycle after load accept; out_ready low holds every out_* stable.
module rec_array_serializer #(
    parameter int ROWS  = 4,
    parameter int COLS  = 2,
    parameter int ADR_W = 4,
    parameter int VAL_W = 4,
    localparam int REC_W  = ADR_W + VAL_W,
    localparam int N      = ROWS * COLS,
    localparam int DATA_W = N * REC_W,
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1,
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADR_W-1:0]  out_adr,
    output logic [VAL_W-1:0]  out_val,
    output logic [ROW_W-1:0]  out_row,
    output logic [COL_W-1:0]  out_col,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [REC_W-1:0]    rec;
    logic                is_last;
    logic                beat;
    logic                load_acc;

    // Explicit mux keeps x/z data out of the index path; only the data bits propagate them.
    always_comb begin
        rec = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) rec = buf_q[i*REC_W +: REC_W];
        end
    end

    assign is_last    = (idx_q == IDX_W'(N - 1));
    assign out_valid  = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign out_last   = out_valid && is_last;
    assign out_adr    = rec[REC_W-1 -: ADR_W];
    assign out_val    = rec[VAL_W-1:0];
    assign out_row    = ROW_W'(int'(idx_q) / COLS);
    assign out_col    = COL_W'(int'(idx_q) % COLS);
    assign beat       = out_valid && out_ready;
    assign load_ready = !rst && (state_q == IDLE || (beat && out_last));
    assign load_acc   = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (load_acc) begin
                    buf_d   = load_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beat) begin
                    if (!is_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (load_acc) begin
                        buf_d = load_data;
                        idx_d = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: doc/rec_array_serializer.md
Name: rec_array_serializer

Overview:
- Reader/unpacker for packed two-dimensional arrays of {adr, val} records, as written by a producer that packs a ROWS x COLS record array into a single flat vector.
- Accepts one whole flat array on a load handshake.
- Emits the records one per beat on a valid/ready stream, tagged with row/column indices and a last flag.
- Serves as the streaming endpoint for packed-struct-array port traffic; must be bit-exact under 4-state simulation.

Parameters:
- ROWS, 4, outer array dimension
- COLS, 2, inner array dimension
- ADR_W, 4, record adr field width
- VAL_W, 4, record val field width
- Derived, not overridable: REC_W = ADR_W+VAL_W; N = ROWS*COLS; DATA_W = N*REC_W

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- load_valid  input  1  load_data is presented
- load_ready  output  1  block can accept a load this cycle
- load_data  input  DATA_W  flat array; element [r][c] occupies bits (r*COLS+c)*REC_W +: REC_W; adr in the upper ADR_W bits, val in the lower VAL_W bits
- out_valid  output  1  record on out_* is valid
- out_ready  input  1  consumer accepts record
- out_adr  output  ADR_W  record adr field
- out_val  output  VAL_W  record val field
- out_row  output  clog2(ROWS) (min 1)  row index r of current record
- out_col  output  clog2(COLS) (min 1)  column index c of current record
- out_last  output  1  current record is index N-1
- busy  output  1  a loaded array is still draining

Behaviour:
- Reset (rst high at an edge):
  - state <= IDLE; out_valid, out_last, busy <= 0; out_adr, out_val, out_row, out_col <= 0; buffer and index cleared.
  - rst overrides all other activity, including mid-drain; the remaining records are discarded.
- load_ready (combinational) = !rst && (state==IDLE || (out_valid && out_ready && out_last)).
- States:
  - IDLE: out_valid=0. When load_valid && load_ready at an edge: capture load_data into the buffer, set idx=0, go to SEND. From that edge on, out_valid=1 and out_* present element 0. Latency from load accept to first record = 1 cycle.
  - SEND: out_* present element idx, with out_row = idx / COLS, out_col = idx % COLS, out_last = (idx==N-1), busy=1.
    - Beat = out_valid && out_ready at an edge.
    - Beat with idx<N-1: idx <= idx+1.
    - Beat with idx==N-1 and no simultaneous load: go to IDLE, out_valid <= 0, busy <= 0.
    - Beat with idx==N-1 and simultaneous load_valid: capture the new array, idx <= 0, stay in SEND. Back-to-back arrays therefore have no bubble.
- Stall: while out_valid && !out_ready, all out_* hold exactly stable.
- load_valid in SEND before the final beat is ignored (load_ready=0). The producer holds load_data until accepted.
- Emission order is strictly ascending idx: row-major, column fastest.
- 4-state fidelity:
  - x and z bits in load_data are stored and emitted unchanged.
  - No masking, no reduction, no inversion.
  - Control outputs (out_valid, out_last, busy, load_ready, out_row, out_col) must never be x/z after reset, whatever the data contents.
- Throughput: one record per cycle when out_ready is held high; N cycles per array.
- Widths: idx is clog2(N) bits (min 1) and never exceeds N-1. There is no wrap except through the final-beat transition.

Test Plan:
- Reset, then load 64'hF7E6D5C4B3A29180 with out_ready=1 -> 8 consecutive beats: (adr,val,row,col) = (8,0,0,0), (9,1,0,1), (A,2,1,0), (B,3,1,1), (C,4,2,0), (D,5,2,1), (E,6,3,0), (F,7,3,1). out_last is high only on the 8th beat; then out_valid=0, busy=0, load_ready=1.
- Same load, with out_ready low for 3 cycles on idx 2 -> out_adr=A, out_val=2, out_row=1, out_col=0 held for all 3 cycles; no record skipped or duplicated.
- Load 64'hx3x2x1x0zzzz1234 -> the idx 0 record is adr=3, val=4, and the x/z records are emitted bit-exact (compare with !==). Control outputs are never x.
- Second array 64'h0123456789ABCDEF presented with load_valid during the final beat of the first array -> the cycle after the last beat shows out_valid=1 with adr=E, val=F, row=0, col=0. No idle cycle occurs.
- rst asserted after 3 beats -> after that edge out_valid=0, busy=0, all out_* = 0. After rst is released load_ready=1, and a fresh load restarts at idx 0.
- load_valid asserted in mid-drain (idx 4) -> load_ready=0, the load is ignored, and the original records 4..7 complete unchanged.
